// File: rtl/tx_iq_stream_buffer_if.sv
// Sample-stream handshake bundle for the TX IQ buffer: upstream write side and DAC read side.
// slave is the buffer's view, master is the producer/consumer view.
interface tx_iq_stream_buffer_if #(
  parameter int IQ_WIDTH = 16
);
  logic                in_valid;
  logic                in_last;
  logic [IQ_WIDTH-1:0] in_i;
  logic [IQ_WIDTH-1:0] in_q;
  logic                in_ready;
  logic                out_ready;
  logic                out_valid;
  logic [IQ_WIDTH-1:0] out_i;
  logic [IQ_WIDTH-1:0] out_q;

  modport slave (
    input  in_valid, in_last, in_i, in_q, out_ready,
    output in_ready, out_valid, out_i, out_q
  );

  modport master (
    output in_valid, in_last, in_i, in_q, out_ready,
    input  in_ready, out_valid, out_i, out_q
  );
endinterface

// File: rtl/tx_iq_stream_buffer.sv
// Frame-oriented IQ sample FIFO feeding the DAC: prefills to a threshold, then streams until the
// last sample of the frame has left, keeping per-frame underrun and sample statistics.
module tx_iq_stream_buffer #(
  parameter int IQ_WIDTH   = 16,
  parameter int DEPTH_LOG2 = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  phy_tx_arestn,
  input  logic                  soft_rst,
  input  logic                  phy_tx_start,
  input  logic [DEPTH_LOG2:0]   prefill_thresh,
  tx_iq_stream_buffer_if.slave  iq,
  output logic                  tx_active,
  output logic                  tx_done,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [CNT_WIDTH-1:0]  underrun_cnt,
  output logic [CNT_WIDTH-1:0]  sample_cnt
);

  localparam int unsigned        DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] ONE_L   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PREFILL, STREAM, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count, count_nxt, eff_thresh;
  logic                    last_written, last_nxt;
  logic [2*IQ_WIDTH-1:0]   mem [DEPTH];
  logic                    full, empty, streaming, wr, rd, start, underrun;

  assign full       = (count == DEPTH_L);
  assign empty      = (count == '0);
  assign streaming  = ((state == PREFILL) || (state == STREAM)) && !soft_rst;

  assign iq.in_ready  = streaming && !full && !last_written;
  assign iq.out_valid = (state == STREAM) && !soft_rst && !empty;
  assign iq.out_i     = iq.out_valid ? mem[rd_ptr][2*IQ_WIDTH-1:IQ_WIDTH] : '0;
  assign iq.out_q     = iq.out_valid ? mem[rd_ptr][IQ_WIDTH-1:0] : '0;

  assign wr        = iq.in_valid && iq.in_ready;
  assign rd        = iq.out_valid && iq.out_ready;
  assign count_nxt = count + {{DEPTH_LOG2{1'b0}}, wr} - {{DEPTH_LOG2{1'b0}}, rd};
  assign last_nxt  = last_written | (wr & iq.in_last);
  assign underrun  = (state == STREAM) && !soft_rst && empty && iq.out_ready && !last_written;
  assign fill_level = count;

  always_comb begin
    eff_thresh = prefill_thresh;
    if (prefill_thresh > DEPTH_L)
      eff_thresh = DEPTH_L;
    else if (prefill_thresh == '0)
      eff_thresh = ONE_L;
  end

  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Prefill exit looks at post-edge occupancy so output can start the cycle the threshold is met.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    tx_active = streaming;
    tx_done   = 1'b0;
    case (state)
      IDLE: begin
        if (phy_tx_start) begin
          start     = 1'b1;
          state_nxt = PREFILL;
        end
      end
      PREFILL: begin
        if ((count_nxt >= eff_thresh) || last_nxt)
          state_nxt = STREAM;
      end
      STREAM: begin
        // last_written means the frame's final sample is the youngest entry, so it is at the head
        // exactly when one entry remains.
        if (rd && last_written && (count == ONE_L))
          state_nxt = DONE;
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (soft_rst) begin
      state_nxt = IDLE;
      start     = 1'b0;
      tx_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_written <= 1'b0;
      underrun_cnt <= '0;
      sample_cnt   <= '0;
    end else if (soft_rst || start) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_written <= 1'b0;
      underrun_cnt <= '0;
      sample_cnt   <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      if (rd)
        rd_ptr <= rd_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      count        <= count_nxt;
      last_written <= last_nxt;
      if (underrun && (underrun_cnt != '1))
        underrun_cnt <= underrun_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (rd && (sample_cnt != '1))
        sample_cnt <= sample_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= {iq.in_i, iq.in_q};
  end

endmodule

// File: doc/tx_iq_stream_buffer.md
TX_IQ_STREAM_BUFFER -- requirements
Module: tx_iq_stream_buffer

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 16, width of each I and Q sample.
REQ-002 SHALL have parameter DEPTH_LOG2, default 6; FIFO depth DEPTH = 2^DEPTH_LOG2 sample pairs.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 phy_tx_arestn  in  1  reset, asynchronous, active-low.
REQ-006 soft_rst  in  1  synchronous clear, same effect as reset.
REQ-007 phy_tx_start  in  1  single-cycle pulse that arms a new frame.
REQ-008 prefill_thresh  in  DEPTH_LOG2+1  samples buffered before output starts.
REQ-009 in_valid / in_last  in  1 each  sample valid / last sample of frame.
REQ-010 in_i, in_q  in  IQ_WIDTH each  input sample pair.
REQ-011 in_ready  out  1  buffer accepts a sample this cycle; upstream hold = ~in_ready.
REQ-012 out_ready  in  1  downstream (DAC side) consumes a sample this cycle.
REQ-013 out_valid  out  1  out_i/out_q hold a frame sample.
REQ-014 out_i, out_q  out  IQ_WIDTH each  output sample pair.
REQ-015 tx_active  out  1  high in PREFILL and STREAM.
REQ-016 tx_done  out  1  one-cycle pulse at frame completion.
REQ-017 fill_level  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-018 underrun_cnt, sample_cnt  out  CNT_WIDTH each  per-frame statistics.

Function
REQ-019 States SHALL be IDLE, PREFILL, STREAM, DONE.
REQ-020 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-021 IDLE: in_ready=0, out_valid=0; phy_tx_start SHALL flush the FIFO, clear both counters and go to PREFILL next cycle.
REQ-022 phy_tx_start outside IDLE SHALL be ignored.
REQ-023 in_ready SHALL be 1 in PREFILL/STREAM only when FIFO is not full and in_last has not yet been accepted in this frame.
REQ-024 Effective threshold SHALL be max(1, min(prefill_thresh, DEPTH)).
REQ-025 PREFILL -> STREAM when fill_level >= effective threshold or a sample with in_last has been written; out_valid=0 in PREFILL.
REQ-026 A sample written at edge N SHALL be counted in fill_level after edge N and readable from the cycle after edge N.
REQ-027 STREAM: out_valid = FIFO not empty; out_i/out_q SHALL show the FIFO head and stay stable while out_valid && !out_ready.
REQ-028 out_i and out_q SHALL be 0 whenever out_valid=0.
REQ-029 Underrun: in STREAM, FIFO empty, out_ready=1, last not yet written -> underrun_cnt +1 per such cycle.
REQ-030 sample_cnt SHALL increment on each output transfer.
REQ-031 Both counters SHALL saturate at all-ones and hold their value in IDLE/DONE until the next phy_tx_start.
REQ-032 Simultaneous write and read SHALL leave fill_level unchanged, including when full (read frees the slot but in_ready reflects the start-of-cycle full) and when empty (no read possible).
REQ-033 Pointers SHALL wrap modulo DEPTH; full/empty SHALL come from a DEPTH_LOG2+1-bit occupancy count.
REQ-034 STREAM -> DONE on the output transfer of the in_last sample; DONE asserts tx_done for one cycle and returns to IDLE next cycle.
REQ-035 tx_active SHALL be 1 exactly in PREFILL and STREAM.

Reset
REQ-036 Reset or soft_rst SHALL force IDLE and empty FIFO, and hold all outputs at 0 (in_ready, out_valid, out_i, out_q, tx_active, tx_done, fill_level, both counters); an in-progress frame SHALL be abandoned without a tx_done pulse.
REQ-037 FIFO storage contents need not be reset.

Verification
REQ-038 Scenario: thresh=4, 10 samples back-to-back, out_ready=1 -> out_valid first rises when fill_level=4; 10 samples out in order; sample_cnt=10, underrun_cnt=0, one tx_done.
REQ-039 Scenario: thresh=2, input gaps of 3 cycles, out_ready=1 -> underrun_cnt counts every empty cycle before the last sample is written; data order intact.
REQ-040 Scenario: DEPTH=64, out_ready=0, 70 samples offered -> in_ready=0 at fill_level=64; out_ready=1 then drains all 70, with no loss or duplicate.
REQ-041 Scenario: 3-sample frame with thresh=8 -> STREAM entered on in_last write; 3 samples out; tx_done pulse.
REQ-042 Scenario: phy_tx_arestn low mid-STREAM -> all outputs 0 asynchronously; no tx_done; next phy_tx_start runs a clean frame.
REQ-043 Scenario: phy_tx_start pulse in STREAM -> ignored; counters not cleared.
